// File: rtl/jts16_rom_arb.sv
// jts16_rom_arb: shares one SDRAM read channel among the char, map and
// scroll tile ROM fetchers. Each requester keeps a one-word cache; misses
// are served one at a time in round-robin order.
//
// Handshake: sdram_req rises with a stable sdram_addr and stays high until
// a one-cycle sdram_ack; a later one-cycle sdram_rdy carries the data (it
// may coincide with sdram_ack). Requesters see x_ok high only while x_cs is
// set and x_addr equals the cached tag.
module jts16_rom_arb #(
    parameter logic [21:0] CHAR_OFFSET = 22'h00000,
    parameter logic [21:0] MAP_OFFSET  = 22'h10000,
    parameter logic [21:0] SCR_OFFSET  = 22'h20000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        char_cs,
    input  logic [12:0] char_addr,
    output logic [31:0] char_data,
    output logic        char_ok,
    input  logic        map_cs,
    input  logic [13:0] map_addr,
    output logic [15:0] map_data,
    output logic        map_ok,
    input  logic        scr_cs,
    input  logic [15:0] scr_addr,
    output logic [31:0] scr_data,
    output logic        scr_ok,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [31:0] sdram_din,
    output logic [1:0]  st_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_t;

    localparam logic [1:0] G_CHAR = 2'd0;
    localparam logic [1:0] G_MAP  = 2'd1;
    localparam logic [1:0] G_SCR  = 2'd2;

    state_t      r_state;
    logic [1:0]  r_grant;
    logic [1:0]  r_last;
    logic [15:0] r_pend_tag;
    logic        r_req;
    logic [21:0] r_addr;

    logic        r_char_valid, r_map_valid, r_scr_valid;
    logic [12:0] r_char_tag;
    logic [13:0] r_map_tag;
    logic [15:0] r_scr_tag;
    logic [31:0] r_char_data;
    logic [15:0] r_map_data;
    logic [31:0] r_scr_data;

    logic        w_busy;
    logic        w_char_hit, w_map_hit, w_scr_hit;
    logic        w_char_miss, w_map_miss, w_scr_miss;
    logic        w_any;
    logic [1:0]  w_pick;
    logic [21:0] w_new_addr;
    logic [15:0] w_new_tag;
    logic        w_fill;

    // Hit compare is combinational so ok drops as soon as the address moves.
    assign w_busy     = (r_state != ST_IDLE);
    assign w_char_hit = r_char_valid & (char_addr == r_char_tag);
    assign w_map_hit  = r_map_valid  & (map_addr  == r_map_tag);
    assign w_scr_hit  = r_scr_valid  & (scr_addr  == r_scr_tag);

    // The requester being served is not a miss until its transaction ends.
    assign w_char_miss = char_cs & ~w_char_hit & ~(w_busy & (r_grant == G_CHAR));
    assign w_map_miss  = map_cs  & ~w_map_hit  & ~(w_busy & (r_grant == G_MAP));
    assign w_scr_miss  = scr_cs  & ~w_scr_hit  & ~(w_busy & (r_grant == G_SCR));
    assign w_any       = w_char_miss | w_map_miss | w_scr_miss;

    assign char_ok   = char_cs & w_char_hit;
    assign map_ok    = map_cs  & w_map_hit;
    assign scr_ok    = scr_cs  & w_scr_hit;
    assign char_data = r_char_data;
    assign map_data  = r_map_data;
    assign scr_data  = r_scr_data;
    assign sdram_req  = r_req;
    assign sdram_addr = r_addr;
    assign st_dbg     = r_state;

    // Data lands on sdram_rdy in WAIT_DATA, or together with ack in WAIT_ACK.
    assign w_fill = ((r_state == ST_WAIT_ACK) & sdram_ack & sdram_rdy) |
                    ((r_state == ST_WAIT_DATA) & sdram_rdy);

    // Round-robin pick: search starts after the last granted requester.
    always_comb begin
        w_pick = G_CHAR;
        case (r_last)
            G_CHAR: begin
                if (w_map_miss)       w_pick = G_MAP;
                else if (w_scr_miss)  w_pick = G_SCR;
                else                  w_pick = G_CHAR;
            end
            G_MAP: begin
                if (w_scr_miss)       w_pick = G_SCR;
                else if (w_char_miss) w_pick = G_CHAR;
                else                  w_pick = G_MAP;
            end
            default: begin
                if (w_char_miss)      w_pick = G_CHAR;
                else if (w_map_miss)  w_pick = G_MAP;
                else                  w_pick = G_SCR;
            end
        endcase
    end

    // SDRAM word address and cache tag for the picked requester.
    always_comb begin
        w_new_addr = CHAR_OFFSET + {8'd0, char_addr, 1'b0};
        w_new_tag  = {3'd0, char_addr};
        case (w_pick)
            G_MAP: begin
                w_new_addr = MAP_OFFSET + {8'd0, map_addr};
                w_new_tag  = {2'd0, map_addr};
            end
            G_SCR: begin
                w_new_addr = SCR_OFFSET + {5'd0, scr_addr, 1'b0};
                w_new_tag  = scr_addr;
            end
            default: ;
        endcase
    end

    // Request FSM: one outstanding SDRAM read at a time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= G_CHAR;
            r_last     <= G_SCR;
            r_pend_tag <= 16'd0;
            r_req      <= 1'b0;
            r_addr     <= 22'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_pick;
                        r_last     <= w_pick;
                        r_pend_tag <= w_new_tag;
                        r_addr     <= w_new_addr;
                        r_req      <= 1'b1;
                        r_state    <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (sdram_ack) begin
                        r_req   <= 1'b0;
                        r_state <= sdram_rdy ? ST_IDLE : ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (sdram_rdy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Cache fill: stored under the tag captured at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_char_valid <= 1'b0;
            r_map_valid  <= 1'b0;
            r_scr_valid  <= 1'b0;
            r_char_tag   <= 13'd0;
            r_map_tag    <= 14'd0;
            r_scr_tag    <= 16'd0;
            r_char_data  <= 32'd0;
            r_map_data   <= 16'd0;
            r_scr_data   <= 32'd0;
        end else if (w_fill) begin
            case (r_grant)
                G_CHAR: begin
                    r_char_valid <= 1'b1;
                    r_char_tag   <= r_pend_tag[12:0];
                    r_char_data  <= sdram_din;
                end
                G_MAP: begin
                    r_map_valid <= 1'b1;
                    r_map_tag   <= r_pend_tag[13:0];
                    r_map_data  <= sdram_din[15:0];
                end
                default: begin
                    r_scr_valid <= 1'b1;
                    r_scr_tag   <= r_pend_tag;
                    r_scr_data  <= sdram_din;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jts16_rom_arb.sv
// Bench for jts16_rom_arb: table of single fetches plus hand sequences for
// address changes, round-robin order, in-flight address change and reset.
module tb_jts16_rom_arb;

    logic        clk;
    logic        rst;
    logic        char_cs;
    logic [12:0] char_addr;
    logic [31:0] char_data;
    logic        char_ok;
    logic        map_cs;
    logic [13:0] map_addr;
    logic [15:0] map_data;
    logic        map_ok;
    logic        scr_cs;
    logic [15:0] scr_addr;
    logic [31:0] scr_data;
    logic        scr_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        sdram_rdy;
    logic [31:0] sdram_din;
    logic [1:0]  st_dbg;

    int n_pass  = 0;
    int n_total = 0;
    int viol    = 0;
    logic outstanding = 1'b0;

    logic [21:0] exp_q[$];

    typedef struct {
        int          who;
        logic [15:0] addr;
        logic [31:0] din;
        logic [21:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    jts16_rom_arb dut (
        .clk        (clk),
        .rst        (rst),
        .char_cs    (char_cs),
        .char_addr  (char_addr),
        .char_data  (char_data),
        .char_ok    (char_ok),
        .map_cs     (map_cs),
        .map_addr   (map_addr),
        .map_data   (map_data),
        .map_ok     (map_ok),
        .scr_cs     (scr_cs),
        .scr_addr   (scr_addr),
        .scr_data   (scr_data),
        .scr_ok     (scr_ok),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_rdy  (sdram_rdy),
        .sdram_din  (sdram_din),
        .st_dbg     (st_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A new request must never appear between ack and rdy.
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 1'b0;
        end else begin
            if (outstanding && sdram_req) viol++;
            if (sdram_rdy)      outstanding = 1'b0;
            else if (sdram_ack) outstanding = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_req(input int who, input logic [15:0] a, input logic cs);
        case (who)
            0: begin char_cs = cs; char_addr = a[12:0]; end
            1: begin map_cs = cs;  map_addr  = a[13:0]; end
            default: begin scr_cs = cs; scr_addr = a; end
        endcase
    endtask

    function automatic logic get_ok(input int who);
        case (who)
            0: return char_ok;
            1: return map_ok;
            default: return scr_ok;
        endcase
    endfunction

    function automatic logic [31:0] get_data(input int who);
        case (who)
            0: return char_data;
            1: return {16'd0, map_data};
            default: return scr_data;
        endcase
    endfunction

    // Wait (bounded) for sdram_req, then compare its address with the scoreboard.
    task automatic wait_req(output int n);
        logic seen;
        logic [21:0] e;
        seen = 1'b0;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n++;
            if (sdram_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("req_seen", 32'(seen), 32'd1);
        if (seen) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_addr: request at %h with empty expected queue", sdram_addr);
            end else begin
                e = exp_q.pop_front();
                if (sdram_addr !== e) $display("FAIL sb_addr: got %h expected %h", sdram_addr, e);
                else n_pass++;
            end
        end
    endtask

    // Ack gap posedges after the request was seen; optionally with rdy in the same cycle.
    task automatic do_ack(input int gap, input logic with_rdy, input logic [31:0] din);
        repeat (gap) @(posedge clk);
        #1;
        check("req_held", 32'(sdram_req), 32'd1);
        sdram_ack = 1'b1;
        if (with_rdy) begin
            sdram_rdy = 1'b1;
            sdram_din = din;
        end
        @(posedge clk); #1;
        sdram_ack = 1'b0;
        sdram_rdy = 1'b0;
        check("req_drop", 32'(sdram_req), 32'd0);
    endtask

    // rdy arrives gap cycles after the ack cycle.
    task automatic do_rdy(input int gap, input logic [31:0] din);
        repeat (gap - 1) @(posedge clk);
        #1;
        sdram_rdy = 1'b1;
        sdram_din = din;
        @(posedge clk); #1;
        sdram_rdy = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] d0, d1, d2;

        rst = 1'b1;
        char_cs = 1'b0; char_addr = '0;
        map_cs = 1'b0;  map_addr = '0;
        scr_cs = 1'b0;  scr_addr = '0;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_din = '0;

        d0 = $urandom; d1 = $urandom; d2 = $urandom;
        vecs[0] = '{0, 16'h0005, 32'hDEADBEEF, 22'h00000A, 32'hDEADBEEF};
        vecs[1] = '{1, 16'h0123, 32'h5555AAAA, 22'h010123, 32'h0000AAAA};
        vecs[2] = '{2, 16'h1234, 32'h12345678, 22'h022468, 32'h12345678};
        vecs[3] = '{0, 16'h1FFF, d0,           22'h003FFE, d0};
        vecs[4] = '{1, 16'h3FFF, d1,           22'h013FFF, {16'd0, d1[15:0]}};
        vecs[5] = '{2, 16'hFFFF, d2,           22'h03FFFE, d2};

        // reset state, with all requesters asking
        repeat (2) @(posedge clk);
        #1;
        char_cs = 1'b1; map_cs = 1'b1; scr_cs = 1'b1;
        #1;
        check("rst_req",  32'(sdram_req), 32'd0);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        check("rst_ok",   32'({char_ok, map_ok, scr_ok}), 32'd0);
        check("rst_char_data", char_data, 32'd0);
        check("rst_map_data",  32'(map_data), 32'd0);
        check("rst_scr_data",  scr_data, 32'd0);
        char_cs = 1'b0; map_cs = 1'b0; scr_cs = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // single fetches from the table
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            set_req(vecs[i].who, vecs[i].addr, 1'b1);
            exp_q.push_back(vecs[i].exp_addr);
            wait_req(n);
            check($sformatf("v%0d_req_latency", i), 32'(n), 32'd2);
            do_ack(2, 1'b0, 32'd0);
            do_rdy(3, vecs[i].din);
            check($sformatf("v%0d_ok", i), 32'(get_ok(vecs[i].who)), 32'd1);
            check($sformatf("v%0d_data", i), get_data(vecs[i].who), vecs[i].exp_data);
            @(posedge clk); #1;
            set_req(vecs[i].who, vecs[i].addr, 1'b0);
        end

        // hit, then address change drops ok in the same cycle
        @(posedge clk); #1;
        char_cs = 1'b1; char_addr = 13'h0005;
        exp_q.push_back(22'h00000A);
        wait_req(n);
        do_ack(1, 1'b0, 32'd0);
        do_rdy(1, 32'hCAFE0005);
        check("hit_ok", 32'(char_ok), 32'd1);
        @(posedge clk); #1;
        char_addr = 13'h0006;
        #1;
        check("chg_ok_low", 32'(char_ok), 32'd0);
        exp_q.push_back(22'h00000C);
        wait_req(n);
        do_ack(1, 1'b0, 32'd0);
        do_rdy(2, 32'hCAFE0006);
        check("chg_ok", 32'(char_ok), 32'd1);
        check("chg_data", char_data, 32'hCAFE0006);
        @(posedge clk); #1;
        char_cs = 1'b0;

        // round robin after reset: two rounds, both starting at char
        do_reset();
        for (int r = 0; r < 2; r++) begin
            logic [15:0] off;
            off = 16'(r);
            d0 = $urandom; d1 = $urandom; d2 = $urandom;
            char_cs = 1'b1; char_addr = 13'h0100 + off[12:0];
            map_cs  = 1'b1; map_addr  = 14'h0200 + off[13:0];
            scr_cs  = 1'b1; scr_addr  = 16'h0300 + off;
            exp_q.push_back(22'h000200 + 22'(2 * r));
            exp_q.push_back(22'h010200 + 22'(r));
            exp_q.push_back(22'h020600 + 22'(2 * r));
            wait_req(n);
            do_ack(1, 1'b0, 32'd0);
            do_rdy(2, d0);
            wait_req(n);
            do_ack(2, 1'b1, d1);
            wait_req(n);
            do_ack(1, 1'b0, 32'd0);
            do_rdy(1, d2);
            check($sformatf("rr%0d_ok", r), 32'({char_ok, map_ok, scr_ok}), 32'd7);
            check($sformatf("rr%0d_char", r), char_data, d0);
            check($sformatf("rr%0d_map", r), 32'(map_data), {16'd0, d1[15:0]});
            check($sformatf("rr%0d_scr", r), scr_data, d2);
            @(posedge clk); #1;
        end
        char_cs = 1'b0; map_cs = 1'b0; scr_cs = 1'b0;

        // scroll address changes while its fetch is in flight
        @(posedge clk); #1;
        d0 = $urandom; d1 = $urandom;
        scr_cs = 1'b1; scr_addr = 16'h0010;
        exp_q.push_back(22'h020020);
        wait_req(n);
        do_ack(1, 1'b0, 32'd0);
        scr_addr = 16'h0011;
        #1;
        check("fly_ok_wait", 32'(scr_ok), 32'd0);
        do_rdy(2, d0);
        check("fly_ok_after", 32'(scr_ok), 32'd0);
        check("fly_data", scr_data, d0);
        exp_q.push_back(22'h020022);
        wait_req(n);
        do_ack(1, 1'b0, 32'd0);
        do_rdy(1, d1);
        check("fly2_ok", 32'(scr_ok), 32'd1);
        check("fly2_data", scr_data, d1);
        @(posedge clk); #1;
        scr_cs = 1'b0;

        // reset in WAIT_DATA; a later rdy must be ignored
        map_cs = 1'b1; map_addr = 14'h0201;
        #1;
        check("pre_rst_map_ok", 32'(map_ok), 32'd1);
        char_cs = 1'b1; char_addr = 13'h0777;
        exp_q.push_back(22'h000EEE);
        wait_req(n);
        do_ack(1, 1'b0, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("wd_rst_req", 32'(sdram_req), 32'd0);
        check("wd_rst_addr", 32'(sdram_addr), 32'd0);
        check("wd_rst_ok", 32'({char_ok, map_ok, scr_ok}), 32'd0);
        char_cs = 1'b0; map_cs = 1'b0;
        sdram_rdy = 1'b1; sdram_din = 32'h0BAD0BAD;
        @(posedge clk); #1;
        sdram_rdy = 1'b0;
        char_cs = 1'b1;
        #1;
        check("stray_rdy_ok", 32'(char_ok), 32'd0);
        check("stray_rdy_data", char_data, 32'd0);
        exp_q.push_back(22'h000EEE);
        wait_req(n);
        do_ack(1, 1'b0, 32'd0);
        do_rdy(1, 32'h07770777);
        check("post_rst_ok", 32'(char_ok), 32'd1);
        check("post_rst_data", char_data, 32'h07770777);
        @(posedge clk); #1;
        char_cs = 1'b0;

        repeat (2) @(posedge clk);
        check("one_outstanding", 32'(viol), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jts16_rom_arb.md
Name: jts16_rom_arb

Overview:
- Shares one SDRAM read channel among the three video ROM fetchers: char tiles, scroll map and scroll tiles.
- Each fetcher uses the codebase's addr/ok style: it drives an address and waits for ok.
- The block caches the last word for each requester, round-robins misses onto the SDRAM port and delivers data back to the requester.
- Sits between jts16_video and the SDRAM controller.

Parameters:
- CHAR_OFFSET, 22'h00000, SDRAM 16-bit word base of the char ROM
- MAP_OFFSET, 22'h10000, SDRAM word base of the map ROM
- SCR_OFFSET, 22'h20000, SDRAM word base of the scroll tile ROM

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- char_cs  in  1  char fetch wanted
- char_addr  in  13  32-bit word index
- char_data  out  32  cached char word
- char_ok  out  1  char_data valid for current char_addr
- map_cs  in  1  map fetch wanted
- map_addr  in  14  16-bit word index
- map_data  out  16  cached map word
- map_ok  out  1  map_data valid
- scr_cs  in  1  scroll tile fetch wanted
- scr_addr  in  16  32-bit word index
- scr_data  out  32  cached scroll word
- scr_ok  out  1  scr_data valid
- sdram_req  out  1  read request, held until acknowledged
- sdram_addr  out  22  word address of request
- sdram_ack  in  1  one-cycle pulse: request accepted
- sdram_rdy  in  1  one-cycle pulse: sdram_din valid
- sdram_din  in  32  read data; bits [15:0] at sdram_addr, [31:16] at +1

Behaviour:
- Reset (synchronous, active high):
  - all valid flags and stored addresses cleared;
  - state IDLE, sdram_req=0, sdram_addr=0;
  - *_data=0, all ok=0.
  - Reset mid-transaction abandons it; a later sdram_rdy is ignored in IDLE.
- Per-requester cache:
  - registers hold {valid, tag address, data}.
  - x_ok = x_cs & valid_x & (x_addr == tag_x); combinational compare, so ok falls in the same cycle the address changes.
  - x_data is the registered cache data, unaffected by address changes.
- Miss: miss_x = x_cs & ~(valid_x & addr match) & ~(busy & grant==x).
- Address mapping:
  - char: CHAR_OFFSET + {char_addr,1'b0}
  - scr: SCR_OFFSET + {scr_addr,1'b0}
  - map: MAP_OFFSET + map_addr; result taken from sdram_din[15:0]
  - Sums are 22-bit, wrapping modulo 2^22.
- Arbitration:
  - Round-robin over char, map, scr.
  - Search starts at the requester after the last granted one; last_grant resets to scr, so char goes first after reset.
- FSM:
  - IDLE: if any miss, latch grant, latch the requester's address as the pending tag, set sdram_addr, assert sdram_req next cycle → WAIT_ACK.
  - WAIT_ACK: hold sdram_req and sdram_addr stable. On sdram_ack, drop sdram_req next cycle → WAIT_DATA. If sdram_ack and sdram_rdy arrive in the same cycle, complete directly as in WAIT_DATA.
  - WAIT_DATA: on sdram_rdy, write data, tag = pending tag, valid=1 → IDLE.
- Timing:
  - New request can be issued the cycle after returning to IDLE.
  - Best-case hit-after-miss: cs/addr at cycle 0, sdram_req high at cycle 1, ok at the cycle after sdram_rdy.
- Address change while in flight: the result is stored under the pending tag. ok stays low because the tag mismatches, and a fresh miss is raised once IDLE is reached. No request is cancelled.
- Requester whose cs drops during its transaction: data is still stored.
- sdram_rdy outside WAIT_ACK/WAIT_DATA: ignored. sdram_ack outside WAIT_ACK: ignored.
- Only one outstanding SDRAM request at any time.

Test Plan:
- Reset then char_cs=1, char_addr=13'h0005:
  - sdram_req=1 with sdram_addr=CHAR_OFFSET+22'h0A the next cycle;
  - ack at +3, rdy at +6 with din=32'hDEADBEEF;
  - char_ok=1 and char_data=32'hDEADBEEF at +7.
- Map fetch map_addr=14'h0123, din=32'h5555AAAA:
  - sdram_addr=22'h10123;
  - map_data=16'hAAAA, map_ok=1.
- All three miss simultaneously after reset:
  - grant order char, map, scr;
  - a second round of misses (last=scr) again begins with char;
  - exactly one sdram_req outstanding throughout.
- Hit then address change:
  - after char_ok=1 at 13'h0005, switch char_addr to 13'h0006;
  - char_ok=0 in the same cycle, new request at CHAR_OFFSET+22'h0C.
- Address change while in flight:
  - scr_addr 16'h0010 issued, changed to 16'h0011 before rdy;
  - tag stored as 16'h0010, scr_ok stays 0, second request at SCR_OFFSET+22'h22.
- Reset asserted in WAIT_DATA:
  - sdram_req=0 and all ok=0 after that cycle;
  - a following sdram_rdy writes nothing (char_ok stays 0).
